// File: rtl/mux4_rr_sel_if.sv
// Bundle of the request/select/handshake signals between the round-robin
// select generator (master) and the requesters plus the downstream consumer (slave).
interface mux4_rr_sel_if;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       out_valid;
  logic       xfer;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output grant,
    output out_valid,
    output xfer
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  grant,
    input  out_valid,
    input  xfer
  );
endinterface

// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a 4:1 mux: grants one requester at a time,
// caps each grant at MAX_BURST transfers and rotates priority on release.
module mux4_rr_sel #(
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  mux4_rr_sel_if.master bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] cnt_q, cnt_d;

  logic       outValid;
  logic       xferNow;
  logic       lastBeat;
  logic       relNow;
  logic [1:0] scanStart;
  logic [2:0] win;

  // Returns {found, index} of the first set request scanning from start upward mod 4.
  function automatic logic [2:0] pickWinner(input logic [3:0] reqv, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (reqv[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    outValid  = (state_q == GRANT) & bus.req[sel_q];
    xferNow   = outValid & bus.out_ready;
    lastBeat  = (cnt_q == 4'(MAX_BURST - 1));
    relNow    = (state_q == GRANT) & (~bus.req[sel_q] | (xferNow & lastBeat));
    // On release the scan starts just past the released channel, making it lowest priority.
    scanStart = relNow ? (sel_q + 2'd1) : ptr_q;
    win       = pickWinner(bus.req, scanStart);

    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (win[2]) begin
          state_d = GRANT;
          sel_d   = win[1:0];
          grant_d = 4'b0001 << win[1:0];
          cnt_d   = 4'd0;
        end else begin
          grant_d = 4'b0000;
        end
      end
      GRANT: begin
        if (relNow) begin
          ptr_d = sel_q + 2'd1;
          if (win[2]) begin
            sel_d   = win[1:0];
            grant_d = 4'b0001 << win[1:0];
            cnt_d   = 4'd0;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            cnt_d   = 4'd0;
          end
        end else if (xferNow) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      grant_q <= 4'b0000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = outValid;
  assign bus.xfer      = xferNow;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Self-checking bench for mux4_rr_sel: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin model.
module tb_mux4_rr_sel;

  localparam int MB = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux4_rr_sel_if bus ();

  mux4_rr_sel #(.MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current owner (-1 when idle), priority start and beats used in this grant.
  int       mOwner;
  int       mPtr;
  int       mUsed;
  logic [1:0] mSel;

  logic [1:0] expSel;
  logic [3:0] expGrant;
  logic       expValid;
  logic       expXfer;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    logic v;
    if (rst) begin
      mOwner = -1;
      mPtr   = 0;
      mUsed  = 0;
      mSel   = 2'd0;
    end else if (mOwner < 0) begin
      w = pick(bus.req, mPtr);
      if (w >= 0) begin
        mOwner = w;
        mSel   = 2'(w);
        mUsed  = 0;
      end
    end else begin
      v = bus.req[mOwner];
      if (v && bus.out_ready) mUsed = mUsed + 1;
      if (!v || mUsed == MB) begin
        mPtr = (mOwner + 1) % 4;
        w    = pick(bus.req, mPtr);
        if (w >= 0) begin
          mOwner = w;
          mSel   = 2'(w);
          mUsed  = 0;
        end else begin
          mOwner = -1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rs);
    @(negedge clk);
    bus.req       = r;
    bus.out_ready = rdy;
    rst           = rs;
    #1;
    expSel   = mSel;
    expGrant = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
    expValid = (mOwner >= 0) && r[mOwner];
    expXfer  = expValid && rdy;
  endtask

  task automatic test_reset();
    applyStimulus(4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checks++;
    if ({bus.sel, bus.grant, bus.out_valid} !== {2'b00, 4'b0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state sel=%b grant=%b valid=%b want sel=00 grant=0000 valid=0",
               bus.sel, bus.grant, bus.out_valid);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checks++;
    if (bus.grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_release_idle grant=%b want 0000", bus.grant);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checks++;
    if ({bus.sel, bus.grant, bus.out_valid} !== {2'b00, 4'b0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL first_grant sel=%b grant=%b valid=%b want 00 0001 1",
               bus.sel, bus.grant, bus.out_valid);
    end
  endtask

  task automatic test_single();
    int nx;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    nx = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0);
      if (bus.xfer === 1'b1) nx++;
      checks++;
      if ({bus.sel, bus.grant} !== {2'b10, 4'b0100}) begin
        errors++;
        $display("[TB] FAIL single_grant c=%0d sel=%b grant=%b want 10 0100", c, bus.sel, bus.grant);
      end
    end
    checks++;
    if (nx != 4) begin
      errors++;
      $display("[TB] FAIL single_xfer_count got %0d want 4", nx);
    end
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checks++;
    if ({bus.grant, bus.xfer, dut.ptr_q, dut.cnt_q} !== {4'b0100, 1'b1, 2'd3, 4'd0}) begin
      errors++;
      $display("[TB] FAIL single_regrant grant=%b xfer=%b ptr=%0d cnt=%0d want 0100 1 3 0",
               bus.grant, bus.xfer, dut.ptr_q, dut.cnt_q);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] want;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      want = 2'((k / MB) % 4);
      checks++;
      if ({bus.sel, bus.grant, bus.xfer} !== {want, 4'b0001 << want, 1'b1}) begin
        errors++;
        $display("[TB] FAIL rotation k=%0d sel=%b grant=%b xfer=%b want sel=%b",
                 k, bus.sel, bus.grant, bus.xfer, want);
      end
    end
  endtask

  task automatic test_early_release();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0011, 1'b1, 1'b0);
    applyStimulus(4'b0011, 1'b1, 1'b0);
    applyStimulus(4'b0011, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checks++;
    if ({bus.sel, bus.out_valid, bus.xfer} !== {2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL early_drop sel=%b valid=%b xfer=%b want 00 0 0",
               bus.sel, bus.out_valid, bus.xfer);
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checks++;
    if ({bus.sel, bus.grant, dut.cnt_q} !== {2'b01, 4'b0010, 4'd0}) begin
      errors++;
      $display("[TB] FAIL early_regrant sel=%b grant=%b cnt=%0d want 01 0010 0",
               bus.sel, bus.grant, dut.cnt_q);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] rdySeq;
    int nx;
    rdySeq = 6'b111001;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    nx = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b1000, rdySeq[c], 1'b0);
      checks++;
      if ({bus.grant, bus.xfer, dut.cnt_q} !== {4'b1000, rdySeq[c], 4'(nx)}) begin
        errors++;
        $display("[TB] FAIL backpressure c=%0d grant=%b xfer=%b cnt=%0d want 1000 %b %0d",
                 c, bus.grant, bus.xfer, dut.cnt_q, rdySeq[c], nx);
      end
      if (rdySeq[c]) nx = (nx + 1) % MB;
    end
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checks++;
    if ({bus.grant, dut.cnt_q} !== {4'b1000, 4'd0}) begin
      errors++;
      $display("[TB] FAIL backpressure_release grant=%b cnt=%0d want 1000 0", bus.grant, dut.cnt_q);
    end
  endtask

  task automatic test_reset_mid_grant();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 2 * MB + 2; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checks++;
    if ({bus.sel, dut.cnt_q} !== {2'b10, 4'd2}) begin
      errors++;
      $display("[TB] FAIL mid_grant_setup sel=%b cnt=%0d want 10 2", bus.sel, dut.cnt_q);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checks++;
    if ({bus.grant, bus.sel, dut.ptr_q, bus.out_valid} !== {4'b0000, 2'b00, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_grant_reset grant=%b sel=%b ptr=%0d valid=%b want 0000 00 0 0",
               bus.grant, bus.sel, dut.ptr_q, bus.out_valid);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL mid_grant_first grant=%b want 0001", bus.grant);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic rdy;
    logic rs;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 59) == 0);
      applyStimulus(r, rdy, rs);
      checks++;
      if ({bus.sel, bus.grant, bus.out_valid, bus.xfer} !== {expSel, expGrant, expValid, expXfer}) begin
        errors++;
        $display("[TB] FAIL random c=%0d req=%b rdy=%b got sel=%b grant=%b v=%b x=%b want sel=%b grant=%b v=%b x=%b",
                 c, r, rdy, bus.sel, bus.grant, bus.out_valid, bus.xfer,
                 expSel, expGrant, expValid, expXfer);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    mOwner        = -1;
    mPtr          = 0;
    mUsed         = 0;
    mSel          = 2'd0;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_backpressure();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sel.md
# mux4_rr_sel

Round-robin select generator that sits directly upstream of the 4:1 multiplexer and drives its 2-bit select. Four requesters raise `req`. The block grants one requester at a time, presents the matching `sel` to the mux, and meters transfers to the downstream consumer with a valid/ready handshake. A grant is capped at `MAX_BURST` transfers, so no channel can starve the others.

## Interface
- `MAX_BURST`, default 4: maximum transfers per grant. Legal range 1..16.
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 4: per-channel request. Bit i means channel i has data on mux input `in[i]`.
- `out_ready`, input, 1: downstream accepts a transfer this cycle.
- `sel`, output, 2: mux select, registered. Equals the index of the granted channel.
- `grant`, output, 4: one-hot grant, registered. All zero when idle.
- `out_valid`, output, 1: the mux output is valid this cycle.
- `xfer`, output, 1: a transfer happens this cycle, defined as `out_valid & out_ready`.

## Operation
- **Internal state:**
  - `state` is IDLE or GRANT.
  - `ptr` (2 bits) is the highest-priority channel.
  - `cnt` (4 bits) counts transfers completed in the current grant.
- **Arbitration function:** pick the first set bit of `req` scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- **IDLE:**
  - If `req != 0`: register `sel` = winner, `grant` = one-hot(winner), `cnt` = 0; next state GRANT.
  - Otherwise hold IDLE with `grant` = 0. `sel` holds its last value.
- **GRANT:**
  - `out_valid = req[sel]`, combinational.
  - On each `xfer`, `cnt` increments.
  - **Release** happens when either:
    - `req[sel]` = 0, or
    - `xfer` and `cnt == MAX_BURST-1`.
- **On release:**
  - `ptr` <= `sel+1` (mod 4, wraps 3 -> 0).
  - Re-arbitrate in the same cycle using the current `req`, with `sel+1` as priority start.
  - The released channel counts only if its `req` is still high; it has lowest priority.
  - If there is a winner: load `sel`/`grant`, set `cnt` = 0, stay in GRANT.
  - Otherwise: `grant` <= 0 and go to IDLE.
- **No release:** `sel`, `grant` and `ptr` hold.
- **Stall:** `out_ready` = 0 while `out_valid` = 1 holds everything. `cnt` does not advance and the grant is never released by the burst limit.
- **Simultaneous events:** a burst-limit release and new requests in the same cycle take the release path above. Both release conditions true at once resolve to a single release.
- **Arithmetic:** `cnt` is a 4-bit unsigned counter. It is never compared past `MAX_BURST-1` and never wraps within a grant. `ptr` and `sel` wrap mod 4.

## Timing
- **Reset values** (next edge with `rst` = 1, including mid-grant):
  - `state` = IDLE, `sel` = 2'b00, `grant` = 4'b0000, `ptr` = 0, `cnt` = 0.
  - `out_valid` = 0 and `xfer` = 0 while in IDLE.
- **Latency:**
  - `req` rising in IDLE gives `grant`/`sel` valid at the next edge. `out_valid` is high from that cycle.
  - Back-to-back grant change happens with zero bubble: new `sel` at the edge after the releasing cycle.
- **Grant duration:** with `out_ready` held at 1 and `req` held, exactly `MAX_BURST` consecutive `xfer` cycles occur per grant.
- **`out_valid` and `xfer`:** combinational from `req` and `out_ready` respectively. All other outputs are registered.
- **`sel` stability:** `sel` never changes in a cycle where `out_valid` is 1 without a release.

## Test plan
- **Reset:** `rst` = 1 for 2 cycles, any `req` -> `sel` = 00, `grant` = 0000, `out_valid` = 0; first grant appears 1 cycle after `rst` falls.
- **Single requester:** `req` = 0100, `out_ready` = 1, `MAX_BURST` = 4 -> `sel` = 10, `grant` = 0100. Expect 4 `xfer`, release, re-grant of channel 2 with no bubble; `ptr` = 3.
- **Rotation:** `req` = 1111 held, `out_ready` = 1, `MAX_BURST` = 4 -> `sel` sequence 00, 01, 10, 11, 00, each for exactly 4 cycles; wrap 3 -> 0 verified.
- **Early release:** `req` = 0011, channel 0 granted, drop `req[0]` after 2 `xfer` -> `out_valid` = 0 that cycle; next edge `sel` = 01, `cnt` = 0.
- **Backpressure:** `req` = 1000, `out_ready` toggled 1, 0, 0, 1, 1, 1 -> `cnt` advances only on `xfer`; release after the 4th `xfer`; `grant` = 1000 throughout.
- **Reset mid-grant:** `req` = 1111, assert `rst` while `sel` = 10 with `cnt` = 2 -> next edge `grant` = 0000, `sel` = 00, `ptr` = 0. After `rst` drops, channel 0 is granted first.
